// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - iterative multiply/divide unit with HI/LO; define HILO_MULDIV_FAST_MUL_EN for single-cycle multiply
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               neg1_q, neg1_d;
    logic               neg2_q, neg2_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               last_step;
    logic               in_signed, in_neg1, in_neg2;
    logic [WIDTH-1:0]   in_mag1, in_mag2;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step, mul_res;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH-1:0]   div_rem, div_quo, div_hi, div_lo;

    assign last_step = (cnt_q == LAST_CNT);

    // Signed ops iterate on magnitudes; remember operand signs for the final fix
    always_comb begin
        in_signed = (op == OP_MULT) || (op == OP_DIV);
        in_neg1   = in_signed && src1[WIDTH-1];
        in_neg2   = in_signed && src2[WIDTH-1];
        in_mag1   = in_neg1 ? -src1 : src1;
        in_mag2   = in_neg2 ? -src2 : src2;
    end

`ifdef HILO_MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_mag, fast_res;

    // Single-cycle magnitude product with sign fix, captured at accept
    always_comb begin
        fast_mag = {{WIDTH{1'b0}}, in_mag1} * {{WIDTH{1'b0}}, in_mag2};
        fast_res = (in_neg1 ^ in_neg2) ? -fast_mag : fast_mag;
    end
`endif

    // One shift-add / restoring-divide step; the last step also applies signs and special cases
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
        mul_step  = {mul_sum, acc_q[WIDTH-1:1]};
        mul_res   = (neg1_q ^ neg2_q) ? -mul_step : mul_step;
        div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, b_q};
        div_rem   = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:WIDTH], acc_q[WIDTH-1]}
                                     : div_trial[WIDTH-1:0];
        div_quo   = {acc_q[WIDTH-2:0], ~div_trial[WIDTH]};
        // Divide by zero: quotient all ones, remainder is the original dividend
        div_lo    = (b_q == '0) ? '1 : ((neg1_q ^ neg2_q) ? -div_quo : div_quo);
        div_hi    = (b_q == '0) ? (neg1_q ? -a_q : a_q)
                                : (neg1_q ? -div_rem : div_rem);
    end

    // Next-state logic; flush always wins and returns to IDLE
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        case (op)
`ifdef HILO_MULDIV_FAST_MUL_EN
                            OP_MULT, OP_MULTU: state_d = S_DONE;
`else
                            OP_MULT, OP_MULTU: state_d = S_MUL;
`endif
                            OP_DIV, OP_DIVU:   state_d = S_DIV;
                            default:           state_d = S_DONE;
                        endcase
                    end
                end
                S_MUL, S_DIV: if (last_step) state_d = S_DONE;
                S_DONE:       if (out_ready) state_d = S_IDLE;
                default:      state_d = S_IDLE;
            endcase
        end
    end

    // Datapath: operand latch, iteration, and HI/LO commit at the output handshake
    always_comb begin
        op_d   = op_q;
        a_d    = a_q;
        b_d    = b_q;
        neg1_d = neg1_q;
        neg2_d = neg2_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        if (flush) begin
            cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_d   = op;
                        a_d    = in_mag1;
                        b_d    = in_mag2;
                        neg1_d = in_neg1;
                        neg2_d = in_neg2;
                        cnt_d  = '0;
                        case (op)
`ifdef HILO_MULDIV_FAST_MUL_EN
                            OP_MULT, OP_MULTU: acc_d = fast_res;
`else
                            OP_MULT, OP_MULTU: acc_d = {{WIDTH{1'b0}}, in_mag2};
`endif
                            OP_DIV, OP_DIVU:   acc_d = {{WIDTH{1'b0}}, in_mag1};
                            default:           acc_d = {src1, src1};
                        endcase
                    end
                end
                S_MUL: begin
                    acc_d = last_step ? mul_res : mul_step;
                    cnt_d = cnt_q + CNT_ONE;
                end
                S_DIV: begin
                    acc_d = last_step ? {div_hi, div_lo} : {div_rem, div_quo};
                    cnt_d = cnt_q + CNT_ONE;
                end
                S_DONE: begin
                    if (out_ready && !cancel) begin
                        case (op_q)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                hi_d = acc_q[2*WIDTH-1:WIDTH];
                                lo_d = acc_q[WIDTH-1:0];
                            end
                            OP_MTHI: hi_d = acc_q[2*WIDTH-1:WIDTH];
                            OP_MTLO: lo_d = acc_q[WIDTH-1:0];
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake and architectural outputs decoded from state
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        out_valid = (state_q == S_DONE);
        hi        = hi_q;
        lo        = lo_q;
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            neg1_q <= 1'b0;
            neg2_q <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            op_q   <= op_d;
            a_q    <= a_d;
            b_q    <= b_d;
            neg1_q <= neg1_d;
            neg2_q <= neg2_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end
endmodule
